// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, datapath mux selects and trap causes.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      IC_RTYPE   = 4'd0,
      IC_JR      = 4'd1,
      IC_ADDI    = 4'd2,
      IC_ANDI    = 4'd3,
      IC_ORI     = 4'd4,
      IC_SLTI    = 4'd5,
      IC_SLTIU   = 4'd6,
      IC_LUI     = 4'd7,
      IC_LOAD    = 4'd8,
      IC_STORE   = 4'd9,
      IC_BEQ     = 4'd10,
      IC_BNE     = 4'd11,
      IC_J       = 4'd12,
      IC_JAL     = 4'd13,
      IC_ILLEGAL = 4'd14
   } icls_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_FUNCT = 3'd2;
   localparam logic [2:0] ALU_AND   = 3'd3;
   localparam logic [2:0] ALU_OR    = 3'd4;
   localparam logic [2:0] ALU_SLT   = 3'd5;
   localparam logic [2:0] ALU_SLTU  = 3'd6;
   localparam logic [2:0] ALU_LUI   = 3'd7;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_BRANCH = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;
   localparam logic [1:0] PCS_RS     = 2'd3;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MDR = 2'd1;
   localparam logic [1:0] M2R_PC  = 2'd2;

   localparam logic [1:0] ASB_RT     = 2'd0;
   localparam logic [1:0] ASB_FOUR   = 2'd1;
   localparam logic [1:0] ASB_IMM    = 2'd2;
   localparam logic [1:0] ASB_IMM_SH = 2'd3;

   localparam logic [1:0] MSZ_WORD = 2'd0;
   localparam logic [1:0] MSZ_HALF = 2'd1;
   localparam logic [1:0] MSZ_BYTE = 2'd2;

   localparam logic [1:0] TRAP_NONE    = 2'd0;
   localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
   localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

   function automatic logic funct_legal(input logic [5:0] fn);
      case (fn)
         FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
         FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational classifier: latched opcode/funct to instruction class,
// memory access size, immediate extension and illegal flag.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output icls_e      icls,
   output logic [1:0] mem_size,
   output logic       load_unsigned,
   output logic       sign_ext,
   output logic       illegal
);

   // opcode/funct to class and per-class attributes
   always_comb begin
      icls          = IC_ILLEGAL;
      mem_size      = MSZ_WORD;
      load_unsigned = 1'b0;
      sign_ext      = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (funct == FN_JR) begin
               icls = IC_JR;
            end else if (funct_legal(funct)) begin
               icls = IC_RTYPE;
            end else begin
               icls = IC_ILLEGAL;
            end
         end
         OP_ADDI, OP_ADDIU: begin icls = IC_ADDI;  sign_ext = 1'b1; end
         OP_SLTI:           begin icls = IC_SLTI;  sign_ext = 1'b1; end
         OP_SLTIU:          begin icls = IC_SLTIU; sign_ext = 1'b1; end
         OP_ANDI:           icls = IC_ANDI;
         OP_ORI:            icls = IC_ORI;
         OP_LUI:            icls = IC_LUI;
         OP_LW: begin icls = IC_LOAD; sign_ext = 1'b1; end
         OP_LHU: begin
            icls = IC_LOAD; sign_ext = 1'b1; mem_size = MSZ_HALF; load_unsigned = 1'b1;
         end
         OP_LBU: begin
            icls = IC_LOAD; sign_ext = 1'b1; mem_size = MSZ_BYTE; load_unsigned = 1'b1;
         end
         OP_SW: begin icls = IC_STORE; sign_ext = 1'b1; end
         OP_SH: begin icls = IC_STORE; sign_ext = 1'b1; mem_size = MSZ_HALF; end
         OP_SB: begin icls = IC_STORE; sign_ext = 1'b1; mem_size = MSZ_BYTE; end
         OP_BEQ: begin icls = IC_BEQ; sign_ext = 1'b1; end
         OP_BNE: begin icls = IC_BNE; sign_ext = 1'b1; end
         OP_J:   icls = IC_J;
         OP_JAL: icls = IC_JAL;
         default: icls = IC_ILLEGAL;
      endcase
   end

   assign illegal = (icls == IC_ILLEGAL);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a bounded
// memory-ready wait and a sticky trap for illegal opcodes and timeouts.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int MEM_TIMEOUT   = 16,
   parameter int ALUOP_W       = 3
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         pc_src,
   output logic               ir_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic [1:0]         mem_size,
   output logic               load_unsigned,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               sign_ext,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [2:0]         state,
   output logic               trap,
   output logic [1:0]         trap_cause
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);

   state_e           state_r;
   state_e           next_state_s;
   logic [CNT_W-1:0] wait_cnt_r;
   logic [5:0]       opcode_r;
   logic [5:0]       funct_r;
   logic             trap_r;
   logic [1:0]       trap_cause_r;
   logic [1:0]       cause_next_s;
   icls_e            icls_s;
   logic [1:0]       msz_s;
   logic             lu_s;
   logic             imm_sext_s;
   logic             illegal_s;
   logic             mem_done_s;
   logic             timeout_s;
   logic             pc_uncond_s;
   logic             branch_taken_s;
   logic [2:0]       alu_op_s;

   mc_ctrl_decode u_decode (
      .opcode        (opcode_r),
      .funct         (funct_r),
      .icls          (icls_s),
      .mem_size      (msz_s),
      .load_unsigned (lu_s),
      .sign_ext      (imm_sext_s),
      .illegal       (illegal_s)
   );

   assign mem_done_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   // The limit cycle is the one where the count would reach MEM_TIMEOUT; a ready there still wins.
   assign timeout_s  = (MEM_TIMEOUT > 0) && !mem_done_s &&
                       (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Wait counter, instruction field latch and sticky trap
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_r   <= '0;
         opcode_r     <= 6'd0;
         funct_r      <= 6'd0;
         trap_r       <= 1'b0;
         trap_cause_r <= TRAP_NONE;
      end else begin
         if (next_state_s != state_r) begin
            wait_cnt_r <= '0;
         end else if ((state_r == ST_FETCH || state_r == ST_MEM) && !mem_done_s &&
                      (wait_cnt_r != '1)) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
         end
         if (state_r == ST_FETCH && mem_done_s) begin
            opcode_r <= opcode;
            funct_r  <= funct;
         end
         if (next_state_s == ST_TRAP && state_r != ST_TRAP) begin
            trap_r       <= 1'b1;
            trap_cause_r <= cause_next_s;
         end
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      cause_next_s = TRAP_NONE;
      case (state_r)
         ST_FETCH: begin
            if (mem_done_s) begin
               next_state_s = ST_DECODE;
            end else if (timeout_s) begin
               next_state_s = ST_TRAP;
               cause_next_s = TRAP_TIMEOUT;
            end else begin
               next_state_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (illegal_s) begin
               next_state_s = ST_TRAP;
               cause_next_s = TRAP_ILLEGAL;
            end else begin
               next_state_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (icls_s)
               IC_LOAD, IC_STORE:                     next_state_s = ST_MEM;
               IC_JR, IC_BEQ, IC_BNE, IC_J, IC_JAL:   next_state_s = ST_FETCH;
               IC_ILLEGAL: begin
                  next_state_s = ST_TRAP;
                  cause_next_s = TRAP_ILLEGAL;
               end
               default:                               next_state_s = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (mem_done_s) begin
               next_state_s = (icls_s == IC_LOAD) ? ST_WB : ST_FETCH;
            end else if (timeout_s) begin
               next_state_s = ST_TRAP;
               cause_next_s = TRAP_TIMEOUT;
            end else begin
               next_state_s = ST_MEM;
            end
         end
         ST_WB:   next_state_s = ST_FETCH;
         ST_TRAP: next_state_s = ST_TRAP;
         default: next_state_s = ST_FETCH;
      endcase
   end

   // Datapath control decode from state and latched instruction
   always_comb begin
      pc_uncond_s    = 1'b0;
      branch_taken_s = 1'b0;
      pc_write_cond  = 1'b0;
      pc_src         = PCS_ALU;
      ir_write       = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_size       = MSZ_WORD;
      load_unsigned  = 1'b0;
      reg_write      = 1'b0;
      reg_dst        = RD_RT;
      mem_to_reg     = M2R_ALU;
      alu_src_a      = 1'b0;
      alu_src_b      = ASB_RT;
      sign_ext       = 1'b0;
      alu_op_s       = ALU_ADD;
      case (state_r)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = ASB_FOUR;
            if (mem_done_s) begin
               ir_write    = 1'b1;
               pc_uncond_s = 1'b1;
            end else begin
               ir_write    = 1'b0;
               pc_uncond_s = 1'b0;
            end
         end
         ST_DECODE: begin
            alu_src_b = ASB_IMM_SH;
            sign_ext  = 1'b1;
         end
         ST_EXEC: begin
            case (icls_s)
               IC_RTYPE: begin alu_src_a = 1'b1; alu_op_s = ALU_FUNCT; end
               IC_JR:    begin pc_uncond_s = 1'b1; pc_src = PCS_RS; end
               IC_ADDI, IC_LOAD, IC_STORE: begin
                  alu_src_a = 1'b1; alu_src_b = ASB_IMM; sign_ext = imm_sext_s;
               end
               IC_ANDI: begin
                  alu_src_a = 1'b1; alu_src_b = ASB_IMM; sign_ext = imm_sext_s; alu_op_s = ALU_AND;
               end
               IC_ORI: begin
                  alu_src_a = 1'b1; alu_src_b = ASB_IMM; sign_ext = imm_sext_s; alu_op_s = ALU_OR;
               end
               IC_SLTI: begin
                  alu_src_a = 1'b1; alu_src_b = ASB_IMM; sign_ext = imm_sext_s; alu_op_s = ALU_SLT;
               end
               IC_SLTIU: begin
                  alu_src_a = 1'b1; alu_src_b = ASB_IMM; sign_ext = imm_sext_s; alu_op_s = ALU_SLTU;
               end
               IC_LUI: begin
                  alu_src_b = ASB_IMM; sign_ext = imm_sext_s; alu_op_s = ALU_LUI;
               end
               IC_BEQ, IC_BNE: begin
                  alu_src_a      = 1'b1;
                  alu_op_s       = ALU_SUB;
                  pc_write_cond  = 1'b1;
                  pc_src         = PCS_BRANCH;
                  branch_taken_s = (icls_s == IC_BEQ) ? zero : !zero;
               end
               IC_J: begin pc_uncond_s = 1'b1; pc_src = PCS_JUMP; end
               IC_JAL: begin
                  pc_uncond_s = 1'b1;
                  pc_src      = PCS_JUMP;
                  reg_write   = 1'b1;
                  reg_dst     = RD_RA;
                  mem_to_reg  = M2R_PC;
               end
               default: pc_uncond_s = 1'b0;
            endcase
         end
         ST_MEM: begin
            mem_size      = msz_s;
            load_unsigned = lu_s;
            mem_read      = (icls_s == IC_LOAD);
            mem_write     = (icls_s == IC_STORE);
         end
         ST_WB: begin
            reg_write = 1'b1;
            if (icls_s == IC_LOAD) begin
               mem_to_reg = M2R_MDR;
            end else if (icls_s == IC_RTYPE) begin
               reg_dst = RD_RD;
            end else begin
               reg_dst = RD_RT;
            end
         end
         default: pc_uncond_s = 1'b0;
      endcase
      pc_write = pc_uncond_s | (pc_write_cond & branch_taken_s);
   end

   assign alu_op     = ALUOP_W'(alu_op_s);
   assign state      = state_r;
   assign trap       = trap_r;
   assign trap_cause = trap_cause_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit (MEM_TIMEOUT=4): per-cycle state and
// control-vector checks for each instruction class, timeout and trap.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       rst_n, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write;
   logic       load_unsigned, reg_write, alu_src_a, sign_ext, trap;
   logic [1:0] pc_src, mem_size, reg_dst, mem_to_reg, alu_src_b, trap_cause;
   logic [2:0] alu_op, state;

   int compared   = 0;
   int mismatched = 0;

   logic [21:0] c_fetch, c_fetch_wait, c_decode, c_exec_r, c_exec_mem;
   logic [21:0] c_mem_lw, c_mem_sw, c_wb_r, c_wb_i, c_wb_ld;

   always #5 clk = ~clk;

   mc_control_unit #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(4), .ALUOP_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .load_unsigned(load_unsigned), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .sign_ext(sign_ext), .alu_op(alu_op), .state(state),
      .trap(trap), .trap_cause(trap_cause)
   );

   wire [21:0] ctl = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
                      mem_size, load_unsigned, reg_write, reg_dst, mem_to_reg,
                      alu_src_a, alu_src_b, sign_ext, alu_op};

   // Field order: pw pwc psrc irw mr mw msz lu rw rd m2r asa asb se aop
   function automatic logic [21:0] exp_ctl(input int pw, pwc, psrc, irw, mr, mw, msz, lu,
                                           rw, rd, m2r, asa, asb, se, aop);
      return {1'(pw), 1'(pwc), 2'(psrc), 1'(irw), 1'(mr), 1'(mw), 2'(msz), 1'(lu),
              1'(rw), 2'(rd), 2'(m2r), 1'(asa), 2'(asb), 1'(se), 3'(aop)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      tick; tick; #1;
      compared++;
      if (state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'd0 || ctl !== c_fetch_wait) begin
         mismatched++;
         $display("FAIL reset state=%0d trap=%0b cause=%0d ctl=%h want 0 0 0 %h",
                  state, trap, trap_cause, ctl, c_fetch_wait);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      logic [2:0]  st [4];
      logic [21:0] cv [4];
      st = '{3'd0, 3'd1, 3'd2, 3'd4};
      cv = '{c_fetch, c_decode, c_exec_r, c_wb_r};
      opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         compared++;
         if (state !== st[i] || ctl !== cv[i]) begin
            mismatched++;
            $display("FAIL add cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                     i, state, ctl, st[i], cv[i]);
         end
         tick;
      end
      #1;
      compared++;
      if (state !== 3'd0) begin
         mismatched++;
         $display("FAIL add_cpi state=%0d want 0", state);
      end
   endtask

   task automatic test_lw;
      logic        rdy [8];
      logic [2:0]  st  [8];
      logic [21:0] cv  [8];
      rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
      cv  = '{c_fetch, c_decode, c_exec_mem, c_mem_lw, c_mem_lw, c_mem_lw, c_mem_lw, c_wb_ld};
      opcode = 6'b100011; funct = 6'd0;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rdy[i];
         #1;
         compared++;
         if (state !== st[i] || ctl !== cv[i]) begin
            mismatched++;
            $display("FAIL lw cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                     i, state, ctl, st[i], cv[i]);
         end
         tick;
      end
      #1;
      compared++;
      if (state !== 3'd0 || trap !== 1'b0) begin
         mismatched++;
         $display("FAIL lw_end state=%0d trap=%0b want 0 0", state, trap);
      end
   endtask

   task automatic test_branch;
      logic [5:0]  bop [4];
      logic        bz  [4];
      int          bpw [4];
      logic [21:0] cv  [3];
      logic [2:0]  st  [3];
      bop = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
      bz  = '{1'b1, 1'b0, 1'b1, 1'b0};
      bpw = '{1, 0, 0, 1};
      st  = '{3'd0, 3'd1, 3'd2};
      for (int c = 0; c < 4; c++) begin
         cv = '{c_fetch, c_decode, exp_ctl(bpw[c], 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)};
         opcode = bop[c]; funct = 6'd0; zero = bz[c]; mem_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (state !== st[i] || ctl !== cv[i]) begin
               mismatched++;
               $display("FAIL branch case%0d cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                        c, i, state, ctl, st[i], cv[i]);
            end
            tick;
         end
         #1;
         compared++;
         if (state !== 3'd0) begin
            mismatched++;
            $display("FAIL branch_cpi case%0d state=%0d want 0", c, state);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_jumps;
      logic [5:0]  jop [3];
      logic [5:0]  jfn [3];
      logic [21:0] jex [3];
      logic [21:0] cv  [3];
      logic [2:0]  st  [3];
      jop = '{6'b000010, 6'b000011, 6'b000000};
      jfn = '{6'd0, 6'd0, 6'b001000};
      jex = '{exp_ctl(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              exp_ctl(1, 0, 2, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0),
              exp_ctl(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      st  = '{3'd0, 3'd1, 3'd2};
      for (int c = 0; c < 3; c++) begin
         cv = '{c_fetch, c_decode, jex[c]};
         opcode = jop[c]; funct = jfn[c]; mem_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (state !== st[i] || ctl !== cv[i]) begin
               mismatched++;
               $display("FAIL jump case%0d cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                        c, i, state, ctl, st[i], cv[i]);
            end
            tick;
         end
         #1;
         compared++;
         if (state !== 3'd0) begin
            mismatched++;
            $display("FAIL jump_cpi case%0d state=%0d want 0", c, state);
         end
      end
   endtask

   task automatic test_itype;
      logic [5:0]  iop [4];
      logic [21:0] iex [4];
      logic [21:0] cv  [4];
      logic [2:0]  st  [4];
      iop = '{6'b001101, 6'b001111, 6'b001011, 6'b001000};
      iex = '{exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 4),
              exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 7),
              exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 6),
              exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0)};
      st  = '{3'd0, 3'd1, 3'd2, 3'd4};
      for (int c = 0; c < 4; c++) begin
         cv = '{c_fetch, c_decode, iex[c], c_wb_i};
         opcode = iop[c]; funct = 6'b100000; mem_ready = 1'b1;
         for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (state !== st[i] || ctl !== cv[i]) begin
               mismatched++;
               $display("FAIL itype case%0d cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                        c, i, state, ctl, st[i], cv[i]);
            end
            tick;
         end
      end
   endtask

   task automatic test_sw_reset;
      logic        rdy [4];
      logic [2:0]  st  [4];
      logic [21:0] cv  [4];
      rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
      st  = '{3'd0, 3'd1, 3'd2, 3'd3};
      cv  = '{c_fetch, c_decode, c_exec_mem, c_mem_sw};
      opcode = 6'b101011; funct = 6'd0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = rdy[i];
         #1;
         compared++;
         if (state !== st[i] || ctl !== cv[i]) begin
            mismatched++;
            $display("FAIL sw cyc%0d state=%0d ctl=%h want state=%0d ctl=%h",
                     i, state, ctl, st[i], cv[i]);
         end
         tick;
      end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      #1;
      compared++;
      if (state !== 3'd0 || mem_write !== 1'b0 || ctl !== c_fetch_wait) begin
         mismatched++;
         $display("FAIL sw_reset state=%0d mem_write=%0b ctl=%h want 0 0 %h",
                  state, mem_write, ctl, c_fetch_wait);
      end
   endtask

   task automatic test_timeout;
      opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         compared++;
         if (state !== 3'd0 || ctl !== c_fetch_wait) begin
            mismatched++;
            $display("FAIL timeout_wait cyc%0d state=%0d ctl=%h want 0 %h",
                     i, state, ctl, c_fetch_wait);
         end
         tick;
      end
      #1;
      compared++;
      if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd2 || ctl !== 22'd0) begin
         mismatched++;
         $display("FAIL timeout_trap state=%0d trap=%0b cause=%0d ctl=%h want 5 1 2 0",
                  state, trap, trap_cause, ctl);
      end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick;
      mem_ready = 1'b1;
      #1;
      compared++;
      if (state !== 3'd0 || ctl !== c_fetch) begin
         mismatched++;
         $display("FAIL timeout_edge_fetch state=%0d ctl=%h want 0 %h", state, ctl, c_fetch);
      end
      tick;
      #1;
      compared++;
      if (state !== 3'd1 || trap !== 1'b0 || trap_cause !== 2'd0) begin
         mismatched++;
         $display("FAIL timeout_edge state=%0d trap=%0b cause=%0d want 1 0 0",
                  state, trap, trap_cause);
      end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_illegal;
      logic [5:0] lop [2];
      logic [5:0] lfn [2];
      lop = '{6'b111111, 6'b000000};
      lfn = '{6'd0, 6'b111111};
      for (int c = 0; c < 2; c++) begin
         opcode = lop[c]; funct = lfn[c]; mem_ready = 1'b1;
         #1;
         compared++;
         if (state !== 3'd0 || ctl !== c_fetch) begin
            mismatched++;
            $display("FAIL illegal_fetch case%0d state=%0d ctl=%h want 0 %h", c, state, ctl, c_fetch);
         end
         tick;
         #1;
         compared++;
         if (state !== 3'd1 || ctl !== c_decode) begin
            mismatched++;
            $display("FAIL illegal_decode case%0d state=%0d ctl=%h want 1 %h", c, state, ctl, c_decode);
         end
         tick;
         for (int i = 0; i < 10; i++) begin
            mem_ready = 1'(i);
            #1;
            compared++;
            if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd1 || ctl !== 22'd0) begin
               mismatched++;
               $display("FAIL illegal_hold case%0d cyc%0d state=%0d trap=%0b cause=%0d ctl=%h want 5 1 1 0",
                        c, i, state, trap, trap_cause, ctl);
            end
            tick;
         end
         rst_n = 1'b0; mem_ready = 1'b0;
         tick;
         rst_n = 1'b1;
         #1;
         compared++;
         if (state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
            mismatched++;
            $display("FAIL illegal_reset case%0d state=%0d trap=%0b cause=%0d want 0 0 0",
                     c, state, trap, trap_cause);
         end
      end
   endtask

   initial begin
      c_fetch      = exp_ctl(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      c_fetch_wait = exp_ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      c_decode     = exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
      c_exec_r     = exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
      c_exec_mem   = exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0);
      c_mem_lw     = exp_ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      c_mem_sw     = exp_ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      c_wb_r       = exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      c_wb_i       = exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      c_wb_ld      = exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      test_reset;
      test_add;
      test_lw;
      test_branch;
      test_jumps;
      test_itype;
      test_sw_reset;
      test_timeout;
      test_illegal;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle successor to the single-cycle combinational MIPS control unit.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB. Drives datapath enables cycle by cycle, and waits on a memory ready handshake with a bounded timeout.
- Latches the opcode and funct fields itself. Flags illegal opcodes and memory timeouts through a sticky trap.
- Sits between the instruction register, memory port and multicycle datapath (PC, IR, regfile, ALU muxes).

Parameters:
- MEM_HANDSHAKE, 1, 1 = wait for mem_ready; 0 = every memory access completes in one cycle (mem_ready ignored).
- MEM_TIMEOUT, 16, maximum wait cycles per memory access before trap; 0 disables the timeout.
- ALUOP_W, 3, width of alu_op.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26] from memory data
- funct  in  6  instr[5:0] from memory data
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  branch PC update, qualified internally (BEQ: zero, BNE: !zero) and OR'd into pc_write
- pc_src  out  2  0 = ALU result, 1 = branch target reg, 2 = jump target, 3 = rs (JR)
- ir_write  out  1  IR load
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_size  out  2  0 = word, 1 = half, 2 = byte
- load_unsigned  out  1  zero-extend loaded byte/half
- reg_write  out  1  regfile write
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  out  2  0 = ALU, 1 = MDR, 2 = PC (JAL)
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = imm, 3 = imm<<2
- sign_ext  out  1  sign-extend immediate
- alu_op  out  ALUOP_W  0 add, 1 sub, 2 funct-decoded, 3 and, 4 or, 5 slt, 6 sltu, 7 lui
- state  out  3  current state
- trap  out  1  sticky trap
- trap_cause  out  2  1 = illegal opcode, 2 = memory timeout

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Outputs are Moore-decoded from state plus the latched opcode/funct. All outputs are 0 unless asserted below.
- Reset (rst_n=0 at a clk edge):
  - state=FETCH, trap=0, trap_cause=0, wait counter=0, latched opcode/funct=0.
  - Reset overrides any state, including a pending memory wait or TRAP.
- FETCH:
  - Assert mem_read; alu_src_a=0, alu_src_b=1, alu_op=add.
  - On mem_ready (or immediately if MEM_HANDSHAKE=0): ir_write=1 and pc_write=1 (pc_src=0) in that same cycle, latch opcode/funct, next state DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=3, sign_ext=1, alu_op=add (branch target).
  - An illegal opcode, or illegal funct under R-type, goes to TRAP with cause 1. Otherwise go to EXEC.
- EXEC, one cycle, per instruction:
  - R-type: alu_src_a=1, alu_src_b=0, alu_op=2; then WB.
  - SLL/SRL: same as other R-type; the shamt path is the datapath's responsibility.
  - JR: pc_write=1, pc_src=3; then FETCH.
  - ADDI/ADDIU: alu_src_a=1, alu_src_b=2, alu_op=add, sign_ext=1; then WB.
  - ANDI/ORI: alu_src_a=1, alu_src_b=2, alu_op=and/or, sign_ext=0; then WB.
  - SLTI/SLTIU: alu_src_a=1, alu_src_b=2, sign_ext=1, alu_op=slt/sltu; then WB.
  - LUI: alu_src_b=2, sign_ext=0, alu_op=lui; then WB.
  - LW/LHU/LBU/SW/SH/SB: alu_src_a=1, alu_src_b=2, sign_ext=1, add; then MEM.
  - BEQ/BNE: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_src=1; then FETCH.
  - J: pc_write=1, pc_src=2; then FETCH.
  - JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; then FETCH.
- MEM:
  - mem_size and load_unsigned are set from the opcode. Assert mem_read for loads, mem_write for stores.
  - Held until mem_ready. Then loads go to WB and stores go to FETCH.
- WB:
  - reg_write=1.
  - ALU ops: reg_dst=1 (R-type) or 0 (I-type), mem_to_reg=0.
  - Loads: reg_dst=0, mem_to_reg=1.
  - Next state FETCH.
- Wait counter:
  - Cleared on entry to FETCH and MEM; increments each cycle mem_ready=0 there.
  - When MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_ready still low: TRAP, cause 2.
  - mem_ready in the same cycle as the limit wins, so no trap.
- TRAP: all enables 0, trap=1, state held until reset.
- CPI: R/I = 4, load = 5, store = 4, branch/jump = 3 (MEM_HANDSHAKE=0 or zero-wait memory).

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode/funct localparams (R_TYPE=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, JAL=000011, JR funct=001000, etc.)
  - state encodings
  - alu_op codes
  - pc_src, reg_dst and mem_to_reg codes
  - trap cause codes
- One sub-module, mc_ctrl_decode: combinational opcode/funct to instruction class, mem_size, sign_ext and illegal flag.
- The FSM and wait counter stay in the top.

Test Plan:
- R-type ADD (000000/100000), mem_ready=1 → states 0,1,2,4,0; ir_write and pc_write in FETCH; alu_op=2 in EXEC; reg_write=1, reg_dst=1 in WB; 4 cycles.
- LW with mem_ready low for 3 cycles in MEM → MEM held 4 cycles with mem_read=1, mem_size=0; then WB with mem_to_reg=1, reg_dst=0.
- BEQ with zero=1 → EXEC shows pc_write_cond=1, pc_src=1, alu_op=sub; then FETCH. BNE with zero=1 → PC not updated.
- Opcode 111111 → DECODE then TRAP, trap=1, cause=1; held 10 cycles; rst_n=0 returns to FETCH with trap=0.
- MEM_TIMEOUT=4, FETCH with mem_ready=0 → TRAP with cause=2 after 4 wait cycles. Same case with mem_ready=1 on the 4th cycle → DECODE, no trap.
- JAL → EXEC asserts pc_write, pc_src=2, reg_write, reg_dst=2, mem_to_reg=2; total 3 cycles. Reset during MEM of SW → next state FETCH, mem_write=0.
